// File: rtl/dram_line_memory.sv
// dram_line_memory: behavioural line-wide main memory with fixed-latency cs/we/ack handshake
module dram_line_memory #(
  parameter int addr_width = 32,
  parameter int data_width = 256,
  parameter int mem_size   = 512,
  parameter int latency    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] addr_i,
  input  logic                  cs,
  input  logic                  we,
  input  logic [data_width-1:0] data_i,
  output logic                  ack,
  output logic [data_width-1:0] data_o
);
  localparam int iw = $clog2(mem_size);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [iw-1:0]         idx_q, idx_d, acc_idx;
  logic                  we_q, we_d, acc_we, acc;
  logic [data_width-1:0] wdata_q, wdata_d, acc_data, rdata_q;
  logic [data_width-1:0] mem_q [mem_size];
  logic                  unused_addr;
  assign unused_addr = ^{addr_i[addr_width-1:iw+5], addr_i[4:0]};
  assign data_o = rdata_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (cs) begin
        state_d = latency == 1 ? DONE : BUSY;
        cnt_d   = 8'(latency - 1);
        idx_d   = addr_i[iw+4:5];
        we_d    = we;
        wdata_d = data_i;
      end
      BUSY: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? DONE : BUSY;
      end
      default: state_d = IDLE;
    endcase
  end
  // latency 1 performs the access on the accepting edge, straight from the inputs
  always_comb begin
    ack      = state_q == DONE;
    acc      = !rst && ((state_q == BUSY && cnt_q == 8'd1) || (state_q == IDLE && cs && latency == 1));
    acc_idx  = state_q == IDLE ? addr_i[iw+4:5] : idx_q;
    acc_we   = state_q == IDLE ? we : we_q;
    acc_data = state_q == IDLE ? data_i : wdata_q;
  end
  always_ff @(posedge clk) begin
    if (acc && acc_we) mem_q[acc_idx] <= acc_data;
  end
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (acc && !acc_we) rdata_q <= mem_q[acc_idx];
  end
endmodule

// File: tb/tb_dram_line_memory.sv
// tb_dram_line_memory: directed checks of latency, aliasing, back-to-back and reset behaviour
module tb_dram_line_memory;
  localparam logic [255:0] da5 = {32{8'hA5}};
  localparam logic [255:0] d0  = {8{32'h0BAD_F00D}};
  localparam logic [255:0] d1  = {8{32'h1111_2222}};
  localparam logic [255:0] d5  = {8{32'h5555_0005}};
  localparam logic [255:0] d6  = {8{32'h6666_0006}};
  localparam logic [255:0] d7o = {8{32'h7070_7070}};
  localparam logic [255:0] d7n = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] dx  = {8{32'hC0FF_EE01}};
  logic clk = 0, rst, cs, we, ack, cs1, we1, ack1;
  logic [31:0] addr, addr1;
  logic [255:0] din, dout, din1, dout1, d1s, d2s;
  logic [5:0] mask;
  int checks = 0, failures = 0, n, acks, t1, t2;
  always #5 clk = ~clk;
  dram_line_memory #(.latency(10)) dut (
    .clk(clk), .rst(rst), .addr_i(addr), .cs(cs), .we(we),
    .data_i(din), .ack(ack), .data_o(dout)
  );
  dram_line_memory #(.latency(1)) dut1 (
    .clk(clk), .rst(rst), .addr_i(addr1), .cs(cs1), .we(we1),
    .data_i(din1), .ack(ack1), .data_o(dout1)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // called at a negedge in IDLE; returns negedges from acceptance to ack (0 = timeout)
  task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                     input bit mangle, output int cyc);
    cs = 1; we = w; addr = a; din = d;
    @(posedge clk);
    @(negedge clk);
    cs = 0;
    if (mangle) begin
      addr = a + 32'h20;
      din  = ~d;
      we   = ~w;
    end
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      if (ack) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask
  task automatic count_acks(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      cnt += int'(ack);
    end
  endtask
  initial begin
    rst = 1; cs = 0; we = 0; addr = 0; din = 0;
    cs1 = 0; we1 = 0; addr1 = 0; din1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    count_acks(20, acks);
    check("idle_ack", acks, 0);
    check("idle_dout", dout, 0);
    rst = 1; cs = 1; we = 1; addr = 32'h40; din = '1;
    @(negedge clk);
    rst = 0; cs = 0;
    count_acks(15, acks);
    check("rst_cs_ack", acks, 0);
    req(1, 32'h40, da5, 0, n);
    check("wr_lat", n, 10);
    check("wr_keeps_dout", dout, 0);
    req(0, 32'h40, 0, 0, n);
    check("rd_lat", n, 10);
    check("rd_data", dout, da5);
    repeat (5) @(negedge clk);
    check("rd_hold", dout, da5);
    req(0, 32'h5C, 0, 0, n);
    check("rd_offset", dout, da5);
    req(0, 32'h4040, 0, 0, n);
    check("rd_alias", dout, da5);
    req(1, 32'h80, d0, 0, n);
    check("rd_hold_after_wr", dout, da5);
    req(1, 32'h60, d1, 1, n);
    check("mangle_lat", n, 10);
    req(0, 32'h60, 0, 0, n);
    check("mangle_line3", dout, d1);
    req(0, 32'h80, 0, 0, n);
    check("mangle_line4", dout, d0);
    req(1, 32'hA0, d5, 0, n);
    req(1, 32'hC0, d6, 0, n);
    cs = 1; we = 0; addr = 32'hA0; t1 = 0; t2 = 0; d1s = 0; d2s = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack && t1 == 0) begin
        t1 = i; d1s = dout; addr = 32'hC0;
      end else if (ack) begin
        t2 = i; d2s = dout; cs = 0;
        break;
      end
    end
    cs = 0;
    @(negedge clk);
    check("b2b_first", t1, 10);
    check("b2b_gap", t2 - t1, 11);
    check("b2b_d1", d1s, d5);
    check("b2b_d2", d2s, d6);
    req(1, 32'hE0, d7o, 0, n);
    cs = 1; we = 1; addr = 32'hE0; din = d7n;
    @(posedge clk);
    @(negedge clk);
    cs = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    count_acks(15, acks);
    check("rst_busy_ack", acks, 0);
    check("rst_busy_dout", dout, 0);
    req(0, 32'hE0, 0, 0, n);
    check("rst_busy_lat", n, 10);
    check("rst_busy_line7", dout, d7o);
    cs1 = 1; we1 = 1; addr1 = 32'h20; din1 = dx;
    @(posedge clk);
    @(negedge clk);
    check("l1_wr_ack", ack1, 1);
    cs1 = 0;
    @(negedge clk);
    check("l1_ack_pulse", ack1, 0);
    check("l1_wr_keeps_dout", dout1, 0);
    cs1 = 1; we1 = 0; mask = 0;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      mask[i] = ack1;
    end
    cs1 = 0;
    check("l1_b2b_mask", mask, 6'b010101);
    check("l1_rd_data", dout1, dx);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
